// File: rtl/mem_port_arbiter.sv
// Shares one byte-addressable data memory port between instruction fetch and load/store.
// Data side has priority; a starvation counter forces a fetch grant after a run of data grants.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_func3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_func3,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned StreakW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {OwnNone, OwnIf, OwnData} owner_e;

    owner_e              owner_q, owner_d;
    logic [StreakW-1:0]  streak_q, streak_d;
    logic                err_q, err_d;
    logic [31:0]         rdata_q, rdata_d;

    logic starved;
    logic if_legal;
    logic d_f3_ok;
    logic d_align_ok;
    logic d_legal;

    assign starved = (streak_q == StreakW'(STARVE_LIMIT));

    // Fetch only wins a contested cycle once the data side has starved it.
    assign if_gnt = if_req & (~d_req | starved);
    assign d_gnt  = d_req & ~if_gnt;

    assign if_legal = (if_addr[1:0] == 2'b00);

    always_comb begin
        d_f3_ok    = 1'b0;
        d_align_ok = 1'b1;
        case (d_func3)
            3'b000, 3'b001, 3'b010: d_f3_ok = 1'b1;
            3'b100, 3'b101:         d_f3_ok = ~d_we;
            default:                d_f3_ok = 1'b0;
        endcase
        case (d_func3)
            3'b010:         d_align_ok = (d_addr[1:0] == 2'b00);
            3'b001, 3'b101: d_align_ok = ~d_addr[0];
            default:        d_align_ok = 1'b1;
        endcase
    end

    assign d_legal = d_f3_ok & d_align_ok;

    // Illegal requests are granted but never reach the memory.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_func3 = 3'b000;
        mem_wdata = 32'h0;
        if (if_gnt && if_legal) begin
            mem_read  = 1'b1;
            mem_addr  = if_addr;
            mem_func3 = 3'b010;
        end else if (d_gnt && d_legal) begin
            mem_read  = ~d_we;
            mem_write = d_we;
            mem_addr  = d_addr;
            mem_func3 = d_func3;
            mem_wdata = d_we ? d_wdata : 32'h0;
        end
    end

    always_comb begin
        owner_d = OwnNone;
        err_d   = 1'b0;
        rdata_d = 32'h0;
        if (if_gnt) begin
            owner_d = OwnIf;
            err_d   = ~if_legal;
            rdata_d = if_legal ? mem_rdata : 32'h0;
        end else if (d_gnt) begin
            owner_d = OwnData;
            err_d   = ~d_legal;
            rdata_d = (d_legal && !d_we) ? mem_rdata : 32'h0;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (!if_req || if_gnt) begin
            streak_d = '0;
        end else if (d_gnt && !starved) begin
            streak_d = streak_q + StreakW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OwnNone;
            streak_q <= '0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            owner_q  <= owner_d;
            streak_q <= streak_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign if_rvalid = (owner_q == OwnIf);
    assign if_err    = if_rvalid & err_q;
    assign if_rdata  = if_rvalid ? rdata_q : 32'h0;
    assign d_rvalid  = (owner_q == OwnData);
    assign d_err     = d_rvalid & err_q;
    assign d_rdata   = d_rvalid ? rdata_q : 32'h0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: byte memory model, grant checks per cycle,
// and a scoreboard of expected responses checked when rvalid is due.
module tb_mem_port_arbiter;

    localparam logic [1:0] GD = 2'b10;
    localparam logic [1:0] GF = 2'b01;
    localparam logic [1:0] GN = 2'b00;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [7:0]  if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [2:0]  d_func3;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic        mem_read, mem_write;
    logic [7:0]  mem_addr;
    logic [2:0]  mem_func3;
    logic [31:0] mem_wdata, mem_rdata;

    int vectors = 0;
    int miscompares = 0;
    int cyc_n = 0;

    typedef struct {
        logic        is_d;
        logic        err;
        logic [31:0] rd;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    mem_port_arbiter #(.ADDR_W(8), .STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .if_err    (if_err),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_func3   (d_func3),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .d_err     (d_err),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_addr  (mem_addr),
        .mem_func3 (mem_func3),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Byte memory with RV32 width/sign handling, reloaded while rst is high.
    logic [7:0]  mem_b [256];
    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] rd_word;
    assign a0 = mem_addr;
    assign a1 = mem_addr + 8'd1;
    assign a2 = mem_addr + 8'd2;
    assign a3 = mem_addr + 8'd3;

    always_comb begin
        rd_word   = {mem_b[a3], mem_b[a2], mem_b[a1], mem_b[a0]};
        mem_rdata = 32'h0;
        case (mem_func3)
            3'b000:  mem_rdata = {{24{rd_word[7]}}, rd_word[7:0]};
            3'b001:  mem_rdata = {{16{rd_word[15]}}, rd_word[15:0]};
            3'b010:  mem_rdata = rd_word;
            3'b100:  mem_rdata = {24'h0, rd_word[7:0]};
            3'b101:  mem_rdata = {16'h0, rd_word[15:0]};
            default: mem_rdata = 32'h0;
        endcase
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_b[i] <= 8'h00;
            mem_b[0] <= 8'd20;
            mem_b[1] <= 8'd9;
            mem_b[2] <= 8'd4;
            mem_b[3] <= 8'd0;
            mem_b[4] <= 8'd20;
        end else if (mem_write) begin
            mem_b[a0] <= mem_wdata[7:0];
            if (mem_func3 != 3'b000) mem_b[a1] <= mem_wdata[15:8];
            if (mem_func3 == 3'b010) begin
                mem_b[a2] <= mem_wdata[23:16];
                mem_b[a3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Response monitor: every cycle either the due response or no rvalid at all.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc_n) begin
            mon_e = sb.pop_front();
            if (mon_e.is_d) begin
                chk("d_rvalid", {30'h0, d_rvalid, if_rvalid}, 32'd2);
                chk("d_err", {31'h0, d_err}, {31'h0, mon_e.err});
                chk("d_rdata", d_rdata, mon_e.rd);
            end else begin
                chk("if_rvalid", {30'h0, d_rvalid, if_rvalid}, 32'd1);
                chk("if_err", {31'h0, if_err}, {31'h0, mon_e.err});
                chk("if_rdata", if_rdata, mon_e.rd);
            end
        end else begin
            chk("no_rvalid", {30'h0, d_rvalid, if_rvalid}, 32'd0);
        end
    end

    task automatic drive(input logic ir, input logic [7:0] ia, input logic dr, input logic we,
                         input logic [2:0] f3, input logic [7:0] da, input logic [31:0] wd);
        if_req  = ir;
        if_addr = ia;
        d_req   = dr;
        d_we    = we;
        d_func3 = f3;
        d_addr  = da;
        d_wdata = wd;
    endtask

    // One cycle: drive, check grant and memory port at negedge, queue the response.
    task automatic cyc(input string tag, input logic ir, input logic [7:0] ia, input logic dr,
                       input logic we, input logic [2:0] f3, input logic [7:0] da,
                       input logic [31:0] wd, input logic [1:0] eg, input logic ee,
                       input logic [31:0] erd);
        logic       xr, xw;
        logic [7:0] xa;
        logic [2:0] xf;
        exp_t       e;
        drive(ir, ia, dr, we, f3, da, wd);
        xr = 1'b0; xw = 1'b0; xa = 8'h0; xf = 3'b000;
        if (eg != GN && !ee) begin
            if (eg == GD) begin
                xr = ~we; xw = we; xa = da; xf = f3;
            end else begin
                xr = 1'b1; xa = ia; xf = 3'b010;
            end
        end
        @(negedge clk);
        chk({tag, "/gnt"}, {30'h0, d_gnt, if_gnt}, {30'h0, eg});
        chk({tag, "/mem_rw"}, {30'h0, mem_read, mem_write}, {30'h0, xr, xw});
        if (xr || xw || eg == GN) begin
            chk({tag, "/mem_addr"}, 32'(mem_addr), 32'(xa));
            chk({tag, "/mem_func3"}, 32'(mem_func3), 32'(xf));
        end
        if (xw || eg == GN) chk({tag, "/mem_wdata"}, mem_wdata, xw ? wd : 32'h0);
        if (eg != GN) begin
            e.is_d = (eg == GD);
            e.err  = ee;
            e.rd   = erd;
            e.due  = cyc_n + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "/rvalid"}, {30'h0, d_rvalid, if_rvalid}, 32'd0);
        chk({tag, "/err"}, {30'h0, d_err, if_err}, 32'd0);
        chk({tag, "/if_rdata"}, if_rdata, 32'h0);
        chk({tag, "/d_rdata"}, d_rdata, 32'h0);
        chk({tag, "/gnt"}, {30'h0, d_gnt, if_gnt}, 32'd0);
        chk({tag, "/mem_rw"}, {30'h0, mem_read, mem_write}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] ord6 [6];
        logic [1:0] ord5 [5];
        ord6 = '{GD, GD, GD, GD, GF, GD};
        ord5 = '{GD, GD, GD, GD, GF};

        rst = 1'b1;
        drive(1'b0, 8'h0, 1'b0, 1'b0, 3'b000, 8'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset");
        @(posedge clk);
        #1;

        // Word load of preloaded bytes.
        cyc("lw0", 0, 8'h0, 1, 0, 3'b010, 8'h0, 32'h0, GD, 0, 32'h00040914);

        // Contested port: four data grants, then one forced fetch.
        for (int i = 0; i < 6; i++)
            cyc("arb", 1, 8'h4, 1, 0, 3'b010, 8'h0, 32'h0, ord6[i], 0,
                (ord6[i] == GD) ? 32'h00040914 : 32'h00000014);

        // Half store then signed/unsigned half and byte loads.
        cyc("sh2", 0, 8'h0, 1, 1, 3'b001, 8'h2, 32'h0000BEEF, GD, 0, 32'h0);
        cyc("lh2", 0, 8'h0, 1, 0, 3'b001, 8'h2, 32'h0, GD, 0, 32'hFFFFBEEF);
        cyc("lhu2", 0, 8'h0, 1, 0, 3'b101, 8'h2, 32'h0, GD, 0, 32'h0000BEEF);
        cyc("lb3", 0, 8'h0, 1, 0, 3'b000, 8'h3, 32'h0, GD, 0, 32'hFFFFFFBE);
        cyc("lbu3", 0, 8'h0, 1, 0, 3'b100, 8'h3, 32'h0, GD, 0, 32'h000000BE);
        cyc("lw0b", 0, 8'h0, 1, 0, 3'b010, 8'h0, 32'h0, GD, 0, 32'hBEEF0914);

        // Illegal data requests: granted, no access, error response.
        cyc("lw1", 0, 8'h0, 1, 0, 3'b010, 8'h1, 32'h0, GD, 1, 32'h0);
        cyc("sh3", 0, 8'h0, 1, 1, 3'b001, 8'h3, 32'h00001234, GD, 1, 32'h0);
        cyc("f3_011", 0, 8'h0, 1, 0, 3'b011, 8'h0, 32'h0, GD, 1, 32'h0);
        cyc("sbu_100", 0, 8'h0, 1, 1, 3'b100, 8'h0, 32'h000000FF, GD, 1, 32'h0);
        cyc("sw2", 0, 8'h0, 1, 1, 3'b010, 8'h2, 32'hFFFFFFFF, GD, 1, 32'h0);
        cyc("lhu1", 0, 8'h0, 1, 0, 3'b101, 8'h1, 32'h0, GD, 1, 32'h0);
        chk("mem0", 32'(mem_b[0]), 32'h14);
        chk("mem2", 32'(mem_b[2]), 32'hEF);
        chk("mem3", 32'(mem_b[3]), 32'hBE);
        chk("mem4", 32'(mem_b[4]), 32'h14);

        // Fetch alignment, plus a byte store seen by a later fetch.
        cyc("f6", 1, 8'h6, 0, 0, 3'b000, 8'h0, 32'h0, GF, 1, 32'h0);
        cyc("f4", 1, 8'h4, 0, 0, 3'b000, 8'h0, 32'h0, GF, 0, 32'h00000014);
        cyc("f5", 1, 8'h5, 0, 0, 3'b000, 8'h0, 32'h0, GF, 1, 32'h0);
        cyc("sb5", 0, 8'h0, 1, 1, 3'b000, 8'h5, 32'h123456A5, GD, 0, 32'h0);
        cyc("f4b", 1, 8'h4, 0, 0, 3'b000, 8'h0, 32'h0, GF, 0, 32'h0000A514);
        cyc("idle", 0, 8'h0, 0, 0, 3'b000, 8'h0, 32'h0, GN, 0, 32'h0);

        // Build a streak, then reset during a granted cycle.
        for (int i = 0; i < 3; i++)
            cyc("pre_rst", 1, 8'h4, 1, 0, 3'b010, 8'h0, 32'h0, GD, 0, 32'hBEEF0914);
        drive(1'b1, 8'h4, 1'b1, 1'b0, 3'b010, 8'h0, 32'h0);
        @(negedge clk);
        chk("rst_cyc/gnt", {30'h0, d_gnt, if_gnt}, {30'h0, GD});
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 8'h0, 1'b0, 1'b0, 3'b000, 8'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("post_rst");
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++)
            cyc("arb_rst", 1, 8'h4, 1, 0, 3'b010, 8'h0, 32'h0, ord5[i], 0,
                (ord5[i] == GD) ? 32'h00040914 : 32'h00000014);

        cyc("idle_end", 0, 8'h0, 0, 0, 3'b000, 8'h0, 32'h0, GN, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
